// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : shared width default, HI/LO op encodings and FSM state encoding
// Revision : 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL      = 3'd1,
        ST_DIV_ITER = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_unit_div_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_seq : iterative unsigned restoring divider, one quotient bit per step
// Revision : 1.0
// ---------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // One extra bit: the shifted remainder can exceed WIDTH bits before the subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign fits    = (shifted >= {1'b0, dvs_q});

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], fits};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul : combinational radix-2 Booth multiplier, signed a*b -> 2W-bit p
// Revision : 1.0
// ---------------------------------------------------------------------------
module mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] acc;
    logic               prev;

    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

    // Each multiplier bit pair {b[i], b[i-1]} selects +a, -a or nothing at weight 2^i.
    always_comb begin
        acc  = '0;
        prev = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case ({b[i], prev})
                2'b01:   acc = acc + (a_ext << i);
                2'b10:   acc = acc - (a_ext << i);
                default: acc = acc;
            endcase
            prev = b[i];
        end
    end

    assign p = acc;

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hilo_unit : multi-cycle MUL/DIV/MTHI/MTLO unit owning the HI/LO registers
// Revision : 1.0
// ---------------------------------------------------------------------------
module hilo_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] Q,
    input  logic [DATA_WIDTH-1:0] M,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   q_q, q_d;
    logic [DATA_WIDTH-1:0]   m_q, m_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic                    dz_q, dz_d;

    logic [2*DATA_WIDTH-1:0] mul_p;
    logic [DATA_WIDTH-1:0]   q_abs, m_abs;
    logic [DATA_WIDTH-1:0]   div_quo, div_rem;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix;
    logic                    div_load, div_step;
    logic                    m_zero;

    mul #(.WIDTH(DATA_WIDTH)) u_mul (
        .a (q_q),
        .b (m_q),
        .p (mul_p)
    );

    // Magnitudes come straight from the inputs so the divider loads on the start edge.
    assign q_abs = Q[DATA_WIDTH-1] ? -Q : Q;
    assign m_abs = M[DATA_WIDTH-1] ? -M : M;

    div_seq #(.WIDTH(DATA_WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (q_abs),
        .divisor   (m_abs),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign m_zero  = (m_q == '0);
    assign quo_fix = (q_q[DATA_WIDTH-1] ^ m_q[DATA_WIDTH-1]) ? -div_quo : div_quo;
    assign rem_fix = q_q[DATA_WIDTH-1] ? -div_rem : div_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MUL:  state_d = ST_MUL;
                        OP_DIV:  state_d = ST_DIV_ITER;
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_MUL:      state_d = ST_DONE;
            ST_DIV_ITER: begin
                if (m_zero)
                    state_d = ST_DONE;
                else if (cnt_q == CNT_W'(1))
                    state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_MUL) || (state_q == ST_DIV_ITER) || (state_q == ST_DIV_FIX);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d = Q;
                    m_d = M;
                    case (op)
                        OP_DIV: begin
                            cnt_d    = CNT_W'(DATA_WIDTH);
                            div_load = 1'b1;
                        end
                        OP_MTHI: hi_d = Q;
                        OP_MTLO: lo_d = Q;
                        default: ;
                    endcase
                end
            end
            ST_MUL: {hi_d, lo_d} = mul_p;
            ST_DIV_ITER: begin
                if (m_zero) begin
                    lo_d = '1;
                    hi_d = q_q;
                    dz_d = 1'b1;
                end else begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            ST_DIV_FIX: begin
                lo_d = quo_fix;
                hi_d = rem_fix;
            end
            default: ;
        endcase
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign div_zero = dz_q;

endmodule
`default_nettype wire
